// File: rtl/gray_ch_serializer_if.sv
// Frame handshake bundle between the gray converter and the serializer.
// master: drives in_valid, data_gray, vld_ch, data_count; slave: drives in_ready.
interface gray_ch_serializer_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_gray;
  logic [7:0]        vld_ch;
  logic [CNT_W-1:0]  data_count;

  modport master (
    output in_valid,
    output data_gray,
    output vld_ch,
    output data_count,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  data_gray,
    input  vld_ch,
    input  data_count,
    output in_ready
  );
endinterface

// File: rtl/gray_ch_serializer.sv
// Serializes one gray frame MSB-first onto the selected channels, 1 bit/clk.
// Ports: clk, rst_n, s (frame in), dout/dout_vld/dout_last, busy, drop_cnt.
module gray_ch_serializer #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_ch_serializer_if.slave  s,
  output logic                 dout,
  output logic [7:0]           dout_vld,
  output logic                 dout_last,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [7:0]        ch_reg;
  logic [CNT_W-1:0]  remaining;
  logic              last_q;

  logic on_last;
  logic xfer;
  logic legal;
  logic take;
  logic drop;

  assign on_last = (state == SHIFT) &&
                   (remaining == ONE);

  assign s.in_ready = (state == IDLE) || on_last;

  assign xfer = s.in_valid && s.in_ready;

  assign legal = (s.data_count != '0) &&
                 (s.data_count <= MAX_CNT) &&
                 (s.vld_ch != 8'h00);

  assign take = xfer && legal;
  assign drop = xfer && !legal;

  // Idle clears shreg and ch_reg so the
  // outputs below are plain register taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      ch_reg    <= '0;
      remaining <= '0;
      last_q    <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

      unique case (1'b1)
        take: begin
          state     <= SHIFT;
          shreg     <= s.data_gray;
          ch_reg    <= s.vld_ch;
          remaining <= s.data_count;
          last_q    <= (s.data_count == ONE);
        end
        (state == SHIFT) && !on_last: begin
          shreg     <= {shreg[DATA_W-2:0], 1'b0};
          remaining <= remaining - ONE;
          last_q    <= (remaining == TWO);
        end
        default: begin
          state     <= IDLE;
          shreg     <= '0;
          ch_reg    <= '0;
          remaining <= '0;
          last_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = shreg[DATA_W-1];
  assign dout_vld  = ch_reg;
  assign dout_last = last_q;
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_gray_ch_serializer.sv
// Directed bench for gray_ch_serializer.
// Checks bit streams, chaining, drops, reset and input hold.
module tb_gray_ch_serializer;

  logic       clk;
  logic       rst_n;
  logic       dout;
  logic [7:0] dout_vld;
  logic       dout_last;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_vec;
  int n_err;

  gray_ch_serializer_if #(
    .DATA_W(128),
    .CNT_W(16)
  ) sif ();

  gray_ch_serializer #(
    .DATA_W(128),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (sif.slave),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_last(dout_last),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [127:0] d,
    input logic [7:0]   ch,
    input logic [15:0]  cnt
  );
    sif.in_valid   = 1'b1;
    sif.data_gray  = d;
    sif.vld_ch     = ch;
    sif.data_count = cnt;
    tick();
    sif.in_valid   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " vld"},   128'(dout_vld),  128'h0);
    chk({tag, " dout"},  128'(dout),      128'h0);
    chk({tag, " last"},  128'(dout_last), 128'h0);
    chk({tag, " busy"},  128'(busy),      128'h0);
    chk({tag, " rdy"},   128'(sif.in_ready), 128'h1);
  endtask

  // Expects a frame already transferred on the last edge.
  task automatic expect_frame(
    input string        tag,
    input logic [127:0] d,
    input logic [7:0]   ch,
    input int           cnt
  );
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s dout[%0d]", tag, i),
          128'(dout), 128'(d[127-i]));
      chk($sformatf("%s vld[%0d]", tag, i),
          128'(dout_vld), 128'(ch));
      chk($sformatf("%s last[%0d]", tag, i),
          128'(dout_last), 128'(i == cnt-1));
      chk($sformatf("%s rdy[%0d]", tag, i),
          128'(sif.in_ready), 128'(i == cnt-1));
      chk($sformatf("%s busy[%0d]", tag, i),
          128'(busy), 128'h1);
      tick();
    end
    chk_idle({tag, " end"});
  endtask

  logic [127:0] da;
  logic [127:0] db;
  logic [127:0] exp_d;
  logic [7:0]   exp_v;

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    sif.in_valid   = 1'b0;
    sif.data_gray  = '0;
    sif.vld_ch     = '0;
    sif.data_count = '0;
    #1;
    chk_idle("reset");
    chk("reset drop", 128'(drop_cnt), 128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 4-bit frame 1010 on channel 0
    send({4'hA, 124'h0}, 8'h01, 16'd4);
    expect_frame("single", {4'hA, 124'h0}, 8'h01, 4);

    // full 128-bit frame
    da = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send(da, 8'hFF, 16'd128);
    expect_frame("full", da, 8'hFF, 128);

    // 5-bit frame; low ones must never appear
    da = {5'b10110, 123'h7FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    send(da, 8'h20, 16'd5);
    expect_frame("five", da, 8'h20, 5);
    chk("five tail", 128'(dout), 128'h0);

    // back-to-back A(16) then B(32)
    da = {16'hC3A5, 112'h0};
    db = {32'h1234_5678, 96'h0};
    send(da, 8'h02, 16'd16);
    for (int i = 0; i < 48; i++) begin
      exp_v = (i < 16) ? 8'h02 : 8'h80;
      exp_d = (i < 16) ? da : db;
      chk($sformatf("b2b dout[%0d]", i), 128'(dout),
          128'(exp_d[(i < 16) ? 127-i : 127-(i-16)]));
      chk($sformatf("b2b vld[%0d]", i),
          128'(dout_vld), 128'(exp_v));
      chk($sformatf("b2b last[%0d]", i),
          128'(dout_last), 128'(i == 15 || i == 47));
      if (i == 15) begin
        chk("b2b rdy", 128'(sif.in_ready), 128'h1);
        send(db, 8'h80, 16'd32);
      end else begin
        tick();
      end
    end
    chk_idle("b2b end");

    // illegal frames
    send({16'hFFFF, 112'h0}, 8'h01, 16'd0);
    chk_idle("ill cnt0");
    send({16'hFFFF, 112'h0}, 8'h01, 16'd144);
    chk_idle("ill cnt144");
    send({16'hFFFF, 112'h0}, 8'h00, 16'd16);
    chk_idle("ill ch0");
    chk("drop 3", 128'(drop_cnt), 128'd3);
    sif.in_valid   = 1'b1;
    sif.data_count = 16'd0;
    sif.vld_ch     = 8'h01;
    for (int i = 0; i < 297; i++) tick();
    sif.in_valid = 1'b0;
    chk("drop sat vld", 128'(dout_vld), 128'h0);
    chk("drop sat", 128'(drop_cnt), 128'd255);

    // dropped frame on last shift cycle
    da = {8'hB4, 120'h0};
    send(da, 8'h08, 16'd8);
    for (int i = 0; i < 7; i++) tick();
    chk("dlast last", 128'(dout_last), 128'h1);
    chk("dlast dout", 128'(dout), 128'(da[120]));
    send({8'hFF, 120'h0}, 8'h00, 16'd8);
    chk_idle("dlast idle");

    // reset at bit 10 of a 64-bit frame
    da = {64'hDEAD_BEEF_0123_4567, 64'h0};
    send(da, 8'h0F, 16'd64);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rst dout[%0d]", i),
          128'(dout), 128'(da[127-i]));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_idle("rst async");
    chk("rst drop", 128'(drop_cnt), 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("rst rel");
    send({16'h8001, 112'h0}, 8'h10, 16'd16);
    expect_frame("rst new", {16'h8001, 112'h0}, 8'h10, 16);

    // inputs changing mid-frame
    da = {16'hF0F0, 112'h0};
    send(da, 8'h04, 16'd16);
    sif.data_gray  = ~da;
    sif.vld_ch     = 8'hFF;
    sif.data_count = 16'd5;
    expect_frame("hold", da, 8'h04, 16);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
